// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command word geometry, opcode constants and the
// program loader state encoding.
package cpu_pkg;

  localparam int CMD_SIZE      = 19;
  localparam int CMD_MEM_SIZE  = 32;
  localparam int CMD_ADDR_SIZE = $clog2(CMD_MEM_SIZE);

  // Bits of the first word byte that land in word[CMD_SIZE-1:16]
  localparam int B0_BITS = CMD_SIZE - 16;
  // Word count must reach CMD_MEM_SIZE itself, hence the extra bit
  localparam int CNT_W   = $clog2(CMD_MEM_SIZE + 1);

  localparam logic [7:0] MAX_COUNT = 8'(CMD_MEM_SIZE);

  localparam logic [3:0] NOP  = 4'd0;
  localparam logic [3:0] LTM  = 4'd1;
  localparam logic [3:0] MTR  = 4'd2;
  localparam logic [3:0] RTR  = 4'd3;
  localparam logic [3:0] JL   = 4'd4;
  localparam logic [3:0] SBT  = 4'd5;
  localparam logic [3:0] SUMM = 4'd6;
  localparam logic [3:0] MTRD = 4'd7;
  localparam logic [3:0] RTM  = 4'd8;
  localparam logic [3:0] JUMP = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } ld_state_t;

  function automatic logic count_legal(input logic [7:0] n);
    return (n != 8'd0) && (n <= MAX_COUNT);
  endfunction

  function automatic logic b0_legal(input logic [7:0] b);
    return (b >> B0_BITS) == 8'd0;
  endfunction

endpackage

// File: rtl/cmd_loader.sv
// Program loader: packs a checksummed byte stream into command words and
// writes them to the command memory while holding the CPU in reset.
//
// state | meaning
// IDLE  | waiting for start
// COUNT | accepting the word count byte
// B0    | accepting word byte 0 (upper bits)
// B1    | accepting word byte 1
// B2    | accepting word byte 2, word write follows
// CHK   | accepting the checksum byte
// DONE  | one-cycle success pulse
// ERR   | load failed, CPU stays held until the next start
module cmd_loader
  import cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [CMD_ADDR_SIZE-1:0] wr_addr,
  output logic [CMD_SIZE-1:0]      wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     cpu_hold
);

  localparam logic [CMD_ADDR_SIZE-1:0] ADDR_ONE = 1;
  localparam logic [CNT_W-1:0]         CNT_ONE  = 1;

  ld_state_t state, state_nxt;

  logic                     load_go;
  logic                     xfer;
  logic [7:0]               csum;
  logic [CNT_W-1:0]         words_left;
  logic [CMD_ADDR_SIZE-1:0] addr_q;
  logic [B0_BITS-1:0]       b0_q;
  logic [7:0]               b1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    load_go   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_COUNT;
          load_go   = 1'b1;
        end
      end
      ST_COUNT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = count_legal(in_data) ? ST_B0 : ST_ERR;
      end
      ST_B0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = b0_legal(in_data) ? ST_B1 : ST_ERR;
      end
      ST_B1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = ST_B2;
      end
      ST_B2: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = (words_left == CNT_ONE) ? ST_CHK : ST_B0;
      end
      ST_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) begin
          state_nxt = ST_COUNT;
          load_go   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    cpu_hold = busy | err;
  end

  assign xfer = in_valid && in_ready;

  // Checksum covers every byte before the checksum byte itself
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      csum       <= '0;
      words_left <= '0;
      addr_q     <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
    end else begin
      wr_en <= 1'b0;
      if (load_go) begin
        csum       <= '0;
        words_left <= '0;
        addr_q     <= '0;
      end else if (xfer) begin
        if (state != ST_CHK) csum <= csum ^ in_data;
        case (state)
          ST_COUNT: words_left <= in_data[CNT_W-1:0];
          ST_B0:    b0_q       <= in_data[B0_BITS-1:0];
          ST_B1:    b1_q       <= in_data;
          ST_B2: begin
            wr_en      <= 1'b1;
            wr_addr    <= addr_q;
            wr_data    <= {b0_q, b1_q, in_data};
            addr_q     <= addr_q + ADDR_ONE;
            words_left <= words_left - CNT_ONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_loader.sv
// Randomized bench for cmd_loader against a stream-level reference model.
module tb_cmd_loader;
  import cpu_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     start = 1'b0;
  logic [7:0]               in_data = 8'h00;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic                     wr_en;
  logic [CMD_ADDR_SIZE-1:0] wr_addr;
  logic [CMD_SIZE-1:0]      wr_data;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic                     cpu_hold;

  cmd_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  stim_q[$];
  bit          exp_ok;
  int          exp_used;

  always @(negedge clk) begin
    if (wr_en) got_q.push_back((32'(wr_addr) << 24) | 32'(wr_data));
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected writes, outcome and number of bytes the loader will consume
  task automatic model();
    int n, b0, word, x;
    exp_q.delete();
    exp_ok = 1'b0;
    n = int'(stim_q[0]);
    if (n < 1 || n > CMD_MEM_SIZE) begin
      exp_used = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      b0 = int'(stim_q[1 + 3*k]);
      if (b0 >= (1 << (CMD_SIZE - 16))) begin
        exp_used = 2 + 3*k;
        return;
      end
      word = b0 * 65536 + int'(stim_q[2 + 3*k]) * 256 + int'(stim_q[3 + 3*k]);
      exp_q.push_back(32'(k * 16777216 + word));
    end
    x = 0;
    for (int i = 0; i <= 3*n; i++) x = x ^ int'(stim_q[i]);
    exp_used = 3*n + 2;
    exp_ok   = (int'(stim_q[3*n + 1]) == x);
  endtask

  task automatic make_stream(input int n, input int mode);
    logic [7:0] x;
    int bad_k;
    stim_q.delete();
    stim_q.push_back(8'(n));
    if (n < 1 || n > CMD_MEM_SIZE) return;
    x = 8'(n);
    bad_k = $urandom_range(0, n - 1);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b0, b1, b2;
      b0 = 8'($urandom_range(0, 7));
      if (mode == 2 && k == bad_k) b0 = 8'($urandom_range(8, 255));
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      stim_q.push_back(b0);
      stim_q.push_back(b1);
      stim_q.push_back(b2);
      x = x ^ b0 ^ b1 ^ b2;
    end
    if (mode == 1) x = x ^ 8'(1 << $urandom_range(0, 7));
    stim_q.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit r;
    int budget;
    in_data  = b;
    in_valid = 1'b1;
    r = 1'b0;
    budget = 0;
    while (!r && budget < 100) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!r) check_eq("xfer_timeout", 32'(r), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // gap_mode < 0 picks a random 0..3 cycle gap between bytes
  task automatic run_case(input string tag, input int gap_mode);
    int g0, d0, g, m;
    model();
    g0 = got_q.size();
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "/ready_at_count"}, 32'(in_ready), 32'd1);
    check_eq({tag, "/hold_at_count"}, 32'(cpu_hold), 32'd1);
    check_eq({tag, "/err_cleared"}, 32'(err), 32'd0);
    for (int i = 0; i < exp_used; i++) begin
      g = (i == exp_used - 1) ? 0 : ((gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode);
      send_byte(stim_q[i], g);
    end
    if (exp_ok) begin
      check_eq({tag, "/done_pulse"}, 32'(done), 32'd1);
      check_eq({tag, "/busy_in_done"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check_eq({tag, "/done_low"}, 32'(done), 32'd0);
      check_eq({tag, "/hold_released"}, 32'(cpu_hold), 32'd0);
    end else begin
      check_eq({tag, "/err_set"}, 32'(err), 32'd1);
      check_eq({tag, "/hold_in_err"}, 32'(cpu_hold), 32'd1);
      check_eq({tag, "/ready_in_err"}, 32'(in_ready), 32'd0);
      check_eq({tag, "/busy_in_err"}, 32'(busy), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "/write_count"}, 32'(got_q.size() - g0), 32'(exp_q.size()));
    m = (got_q.size() - g0 < exp_q.size()) ? got_q.size() - g0 : exp_q.size();
    for (int i = 0; i < m; i++) check_eq({tag, "/write"}, got_q[g0 + i], exp_q[i]);
    check_eq({tag, "/done_count"}, 32'(done_cnt - d0), 32'(exp_ok));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g0, n, mode;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst/in_ready", 32'(in_ready), 32'd0);
    check_eq("rst/wr_en", 32'(wr_en), 32'd0);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/done", 32'(done), 32'd0);
    check_eq("rst/err", 32'(err), 32'd0);
    check_eq("rst/cpu_hold", 32'(cpu_hold), 32'd0);
    check_eq("rst/wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst/wr_data", 32'(wr_data), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle/in_ready", 32'(in_ready), 32'd0);

    stim_q = '{8'h02, 8'h05, 8'h00, 8'h3F, 8'h02, 8'h12, 8'h34, 8'h1C};
    g0 = got_q.size();
    run_case("good_n2", 0);
    check_eq("good_n2/word0", got_q[g0], 32'h0005003F);
    check_eq("good_n2/word1", got_q[g0 + 1], 32'h01021234);

    g0 = got_q.size();
    run_case("backpressure", 3);
    check_eq("backpressure/word0", got_q[g0], 32'h0005003F);
    check_eq("backpressure/word1", got_q[g0 + 1], 32'h01021234);

    stim_q = '{8'h00};
    run_case("bad_count_0", 0);
    stim_q = '{8'h21};
    run_case("bad_count_33", 0);
    stim_q = '{8'h20};
    stim_q.push_back(8'h08);
    run_case("bad_b0_first", 0);

    stim_q = '{8'h01, 8'h08};
    run_case("bad_b0", 0);
    make_stream(1, 0);
    run_case("recover", 0);

    stim_q = '{8'h02, 8'h05, 8'h00, 8'h3F, 8'h02, 8'h12, 8'h34, 8'h1D};
    run_case("bad_chk", 0);

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    reset = 1'b0;
    #1;
    check_eq("midrst/in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst/busy", 32'(busy), 32'd0);
    check_eq("midrst/cpu_hold", 32'(cpu_hold), 32'd0);
    check_eq("midrst/err", 32'(err), 32'd0);
    check_eq("midrst/wr_en", 32'(wr_en), 32'd0);
    check_eq("midrst/wr_data", 32'(wr_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_data  = 8'h02;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("after_rst/in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    make_stream(3, 0);
    run_case("after_rst_load", 0);

    for (int t = 0; t < 20; t++) begin
      mode = $urandom_range(0, 3);
      if (t % 5 == 4) begin
        n = (($urandom_range(0, 1)) == 0) ? 0 : int'($urandom_range(33, 255));
        make_stream(n, 0);
      end else begin
        n = (t == 3) ? CMD_MEM_SIZE : int'($urandom_range(1, CMD_MEM_SIZE));
        make_stream(n, (mode <= 1) ? 0 : mode - 1);
      end
      run_case("random", -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_loader.md
# cmd_loader

Program loader for the multi-cycle CPU. It takes a byte stream on a valid/ready handshake, packs it into CMD_SIZE-bit instruction words, writes them sequentially into the command memory from address 0, and verifies an XOR checksum. The CPU is held in reset while loading is in progress. This block replaces the static file preload as the writer side of the command memory. The CPU fetch path remains the reader.

## Interface
- CMD_SIZE, 19, instruction word width; must be ≤ 24 and > 16.
- CMD_MEM_SIZE, 32, command memory depth in words.
- CMD_ADDR_SIZE, $clog2(CMD_MEM_SIZE), write address width.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; asserting it forces all state and outputs to reset values immediately.
- start  in  1  level-sampled each cycle; begins a load when the block is in IDLE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle. A byte transfers when in_valid && in_ready.
- wr_en  out  1  one-cycle command memory write strobe.
- wr_addr  out  CMD_ADDR_SIZE  write address.
- wr_data  out  CMD_SIZE  write word.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load ends successfully.
- err  out  1  sticky error flag; cleared by the next accepted start.
- cpu_hold  out  1  drives the CPU reset. High while busy and while in ERR.

## Operation
- Stream format: a count byte N, then N × 3 word bytes, then 1 checksum byte.
- The count byte N must satisfy 1 ≤ N ≤ CMD_MEM_SIZE. Any other value moves the block to ERR.
- Each word is 3 bytes, big-endian:
  - b0[CMD_SIZE-17:0] maps to word[CMD_SIZE-1:16]. All higher bits of b0 must be 0, otherwise ERR.
  - b1 maps to word[15:8].
  - b2 maps to word[7:0].
- Checksum byte must equal the XOR of all preceding bytes, count byte included. Mismatch moves the block to ERR.
- States:
  - IDLE: waits for start.
  - COUNT: start seen; accepts the count byte.
  - B0, B1, B2: accept the three bytes of one word.
  - CHK: accepts the checksum byte.
  - DONE: one cycle, then IDLE.
  - ERR: held until start, then COUNT.
- Transitions:
  - COUNT → B0 on a valid count.
  - B0 → B1 → B2 on each accepted byte.
  - B2 → B0 if more words remain, else B2 → CHK.
  - CHK → DONE on a checksum match, CHK → ERR on a mismatch.
- in_ready is 1 exactly in COUNT, B0, B1, B2 and CHK. The state only advances on a transfer. in_valid gaps stall the block indefinitely, with no timeout.
- Word k (k = 0..N-1) is written at wr_addr = k.
- A bad b0 enters ERR without writing that word. Words written earlier remain in memory.
- A checksum error does not undo writes. err=1 and cpu_hold stays high, so the CPU never runs an unverified image.
- start in any state other than IDLE or ERR is ignored.
- Outputs per state:
  - busy = 1 in COUNT through DONE.
  - cpu_hold = busy | (state == ERR).
  - done = (state == DONE).
  - err = (state == ERR).

## Timing
- Reset values:
  - state = IDLE.
  - in_ready, wr_en, busy, done, err, cpu_hold = 0.
  - wr_addr, wr_data = 0.
  - Checksum accumulator = 0.
- start sampled high in IDLE or ERR → COUNT on the next cycle. The accumulator and word counter are cleared on the same edge.
- wr_en is registered: it is high for exactly one cycle, the cycle after the b2 transfer. wr_addr and wr_data are valid in that cycle.
- Minimum load time with in_valid held high: 1 + 3N + 1 transfer cycles, plus 1 DONE cycle.
- done is asserted in the cycle after the checksum transfer.
- Reset mid-load aborts immediately. Partial memory contents are unspecified, and cpu_hold drops to 0.

## Structure
- Shared package cpu_pkg holds:
  - CMD_SIZE, CMD_MEM_SIZE, CMD_ADDR_SIZE.
  - The opcode constants (NOP, LTM, MTR, RTR, JL, SBT, SUMM, MTRD, RTM, JUMP), shared by the CPU and by test stimulus.
  - The loader state encoding.
- No sub-module. Single FSM with a word counter, byte shift register and XOR accumulator. The dual-port command memory is instantiated at the top level, outside this block.

## Test plan
- Good load, N=2: send 02, 05 00 3F, 02 12 34, checksum 1C. Required: writes (0, 0x5003F) and (1, 0x21234); done pulses once; err=0; cpu_hold falls with done.
- Bad count: start, send 00 → err=1, no wr_en, in_ready=0, cpu_hold=1. Repeat with 21 (33) → same response.
- Bad b0: send 01, then 08 → err=1 immediately, no write. A subsequent start followed by a valid stream clears err and loads correctly.
- Bad checksum: the good-load stream with checksum 1D → both writes occur, done=0, err=1, cpu_hold stays 1.
- Backpressure: the good-load stream with in_valid low for 3 cycles between every byte → identical writes and done; no byte is lost or duplicated.
- Reset mid-load: assert reset after the b1 of word 0 → all outputs 0 at once. After release, the block is in IDLE and start is required before any in_ready.
